// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  // Grant index width; a single-channel build still carries a 1-bit index.
  function automatic int unsigned grant_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational winner select: lowest pending index, or first pending at/after start (wrapping).
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int unsigned N_CH = 2,
  parameter int unsigned GW   = grant_w(N_CH)
) (
  input  logic [N_CH-1:0] pend,
  input  logic [GW-1:0]   start,
  input  logic            rr_mode,
  output logic            valid,
  output logic [GW-1:0]   idx
);

  int j;

  // Loops run high-to-low so the smallest offset is the last (winning) assignment.
  always_comb begin
    valid = |pend;
    idx   = '0;
    j     = 0;
    if (rr_mode) begin
      for (int k = int'(N_CH) - 1; k >= 0; k--) begin
        j = int'(start) + k;
        if (j >= int'(N_CH)) j = j - int'(N_CH);
        if (pend[j]) idx = GW'(j);
      end
    end else begin
      for (int k = int'(N_CH) - 1; k >= 0; k--) begin
        if (pend[k]) idx = GW'(k);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-channel requester-to-main-memory arbiter, one outstanding transaction,
// fixed-priority or round-robin selection with registered request capture.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int unsigned N_CH     = 2,
  parameter  int unsigned AW       = 32,
  parameter  int unsigned DW       = 32,
  parameter  int unsigned ARB_MODE = 1,
  localparam int unsigned GW       = grant_w(N_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   req_rd,
  input  logic [N_CH-1:0]   req_wr,
  input  logic [N_CH*AW-1:0] req_addr,
  input  logic [N_CH*DW-1:0] req_wdata,
  output logic [N_CH-1:0]   req_ready,
  output logic [DW-1:0]     req_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  input  logic              mem_ready,
  output logic [GW-1:0]     grant_id,
  output logic              busy
);

  arb_state_t      state;
  logic [GW-1:0]   rr_ptr;
  logic            op_wr;
  logic [N_CH-1:0] pend_c;
  logic            pick_valid_c;
  logic [GW-1:0]   pick_idx_c;

  // A channel asserting both rd and wr is served as a write.
  assign pend_c = req_rd | req_wr;

  rr_picker #(
    .N_CH (N_CH),
    .GW   (GW)
  ) u_picker (
    .pend    (pend_c),
    .start   (rr_ptr),
    .rr_mode (1'(ARB_MODE == ARB_RR)),
    .valid   (pick_valid_c),
    .idx     (pick_idx_c)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      op_wr     <= 1'b0;
      req_ready <= '0;
      req_rdata <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
    end else begin
      req_ready <= '0;
      case (state)
        IDLE: begin
          if (pick_valid_c) begin
            grant_id  <= pick_idx_c;
            op_wr     <= req_wr[pick_idx_c];
            mem_wr    <= req_wr[pick_idx_c];
            mem_rd    <= ~req_wr[pick_idx_c];
            mem_addr  <= req_addr[32'(pick_idx_c) * AW +: AW];
            mem_wdata <= req_wdata[32'(pick_idx_c) * DW +: DW];
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            if (!op_wr) req_rdata <= mem_rdata;
            req_ready <= N_CH'(1) << grant_id;
            state     <= RESP;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (ARB_MODE == ARB_RR) begin
            rr_ptr <= (32'(grant_id) == N_CH - 1) ? '0 : grant_id + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: 2-channel RR instance plus 3-channel RR and fixed instances.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic [1:0]  req_rd2, req_wr2, req_ready2;
  logic [63:0] req_addr2, req_wdata2;
  logic [31:0] req_rdata2, mem_addr2, mem_wdata2, mem_rdata2;
  logic        mem_rd2, mem_wr2, mem_ready2, busy2;
  logic [0:0]  grant2;

  logic [2:0]  req_rd3, req_wr3;
  logic [95:0] req_addr3, req_wdata3;
  logic [31:0] mem_rdata3;

  logic [2:0]  ready3r, ready3f;
  logic [31:0] rdata3r, rdata3f, addr3r, addr3f, wdata3r, wdata3f;
  logic        rd3r, rd3f, wr3r, wr3f, busy3r, busy3f;
  logic        mem_ready3r, mem_ready3f;
  logic [1:0]  grant3r, grant3f;

  // Zero-latency memory for the contention instances.
  assign mem_ready3r = rd3r | wr3r;
  assign mem_ready3f = rd3f | wr3f;

  mem_arbiter #(.N_CH(2), .AW(32), .DW(32), .ARB_MODE(1)) dut2 (
    .clk(clk), .reset(reset), .req_rd(req_rd2), .req_wr(req_wr2),
    .req_addr(req_addr2), .req_wdata(req_wdata2), .req_ready(req_ready2),
    .req_rdata(req_rdata2), .mem_rd(mem_rd2), .mem_wr(mem_wr2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2),
    .mem_ready(mem_ready2), .grant_id(grant2), .busy(busy2)
  );

  mem_arbiter #(.N_CH(3), .AW(32), .DW(32), .ARB_MODE(1)) dut3r (
    .clk(clk), .reset(reset), .req_rd(req_rd3), .req_wr(req_wr3),
    .req_addr(req_addr3), .req_wdata(req_wdata3), .req_ready(ready3r),
    .req_rdata(rdata3r), .mem_rd(rd3r), .mem_wr(wr3r),
    .mem_addr(addr3r), .mem_wdata(wdata3r), .mem_rdata(mem_rdata3),
    .mem_ready(mem_ready3r), .grant_id(grant3r), .busy(busy3r)
  );

  mem_arbiter #(.N_CH(3), .AW(32), .DW(32), .ARB_MODE(0)) dut3f (
    .clk(clk), .reset(reset), .req_rd(req_rd3), .req_wr(req_wr3),
    .req_addr(req_addr3), .req_wdata(req_wdata3), .req_ready(ready3f),
    .req_rdata(rdata3f), .mem_rd(rd3f), .mem_wr(wr3f),
    .mem_addr(addr3f), .mem_wdata(wdata3f), .mem_rdata(mem_rdata3),
    .mem_ready(mem_ready3f), .grant_id(grant3f), .busy(busy3f)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int oh_idx(input logic [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i]) return i;
    return 9;
  endfunction

  int rd_cnt;
  int g_rr[4];
  int g_fx[4];
  int n_rr;
  int n_fx;

  initial begin
    reset      = 1'b0;
    req_rd2    = 2'b11;
    req_wr2    = 2'b00;
    req_addr2  = 64'h0;
    req_wdata2 = 64'h0;
    mem_rdata2 = 32'h0;
    mem_ready2 = 1'b0;
    req_rd3    = 3'b000;
    req_wr3    = 3'b000;
    req_addr3  = 96'h0;
    req_wdata3 = 96'h0;
    mem_rdata3 = 32'h0;

    // Reset held with requests pending.
    repeat (3) tick();
    chk("rst_strobes", {mem_rd2, mem_wr2, busy2, grant2}, 4'h0);
    chk("rst_ready", req_ready2, 2'b00);
    chk("rst_data", {mem_addr2, mem_wdata2}, 64'h0);
    chk("rst_rdata", req_rdata2, 32'h0);
    reset = 1'b1;

    tick();
    chk("first_grant", {mem_rd2, mem_wr2, grant2, busy2}, 4'b1001);
    mem_ready2 = 1'b1;
    tick();
    chk("first_ready", {req_ready2, mem_rd2}, 3'b010);
    mem_ready2 = 1'b0;
    req_rd2    = 2'b00;
    tick();
    chk("first_idle", {req_ready2, busy2}, 3'b000);

    // Single read on ch1 with four strobe cycles.
    req_addr2[63:32] = 32'h40;
    req_rd2          = 2'b10;
    tick();
    chk("rd_grant", {mem_rd2, mem_wr2, grant2}, 3'b101);
    chk("rd_addr", mem_addr2, 32'h40);
    rd_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (mem_rd2) rd_cnt++;
      if (k == 3) begin
        mem_ready2 = 1'b1;
        mem_rdata2 = 32'hDEADBEEF;
      end
      tick();
    end
    mem_ready2 = 1'b0;
    req_rd2    = 2'b00;
    chk("rd_strobe_len", 64'(rd_cnt), 64'd4);
    chk("rd_ready", {req_ready2, mem_rd2, busy2}, 4'b1001);
    chk("rd_rdata", req_rdata2, 32'hDEADBEEF);
    tick();
    chk("rd_done", {req_ready2, busy2}, 3'b000);

    // Single write on ch0; inputs changed mid-access must not leak through.
    req_addr2[31:0]  = 32'h80;
    req_wdata2[31:0] = 32'h1234;
    req_wr2          = 2'b01;
    tick();
    chk("wr_grant", {mem_wr2, mem_rd2, grant2}, 3'b100);
    chk("wr_addr", mem_addr2, 32'h80);
    chk("wr_wdata", mem_wdata2, 32'h1234);
    req_addr2[31:0]  = 32'h99;
    req_wdata2[31:0] = 32'h5555;
    tick();
    chk("wr_hold_addr", mem_addr2, 32'h80);
    chk("wr_hold_wdata", mem_wdata2, 32'h1234);
    chk("wr_hold_strobe", {mem_wr2, mem_rd2}, 2'b10);
    mem_ready2 = 1'b1;
    mem_rdata2 = 32'hCAFEF00D;
    tick();
    chk("wr_ready", {req_ready2, mem_wr2}, 3'b010);
    chk("wr_rdata_kept", req_rdata2, 32'hDEADBEEF);
    mem_ready2      = 1'b0;
    req_wr2         = 2'b00;
    req_addr2[31:0] = 32'h80;
    tick();

    // Reset during ACCESS abandons the transaction.
    req_rd2 = 2'b10;
    tick();
    chk("mr_grant", {mem_rd2, grant2}, 2'b11);
    tick();
    chk("mr_access", {mem_rd2, busy2}, 2'b11);
    reset = 1'b0;
    tick();
    chk("mr_abort", {mem_rd2, mem_wr2, busy2, req_ready2}, 5'b0);
    reset      = 1'b1;
    req_rd2    = 2'b00;
    mem_ready2 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      mem_ready2 = 1'b0;
      chk("mr_no_ready", {req_ready2, busy2, mem_rd2}, 4'b0);
    end

    // Dual rd+wr on ch0 is served as a write.
    req_rd2 = 2'b01;
    req_wr2 = 2'b01;
    tick();
    chk("dual_strobe", {mem_wr2, mem_rd2, grant2}, 3'b100);
    chk("dual_addr", mem_addr2, 32'h80);
    mem_ready2 = 1'b1;
    tick();
    chk("dual_ready", req_ready2, 2'b01);
    mem_ready2 = 1'b0;
    req_rd2    = 2'b00;
    req_wr2    = 2'b00;
    tick();

    // Three channels requesting continuously.
    reset = 1'b0;
    tick();
    req_rd3 = 3'b111;
    tick();
    reset = 1'b1;
    n_rr  = 0;
    n_fx  = 0;
    for (int k = 0; k < 4; k++) begin
      g_rr[k] = 9;
      g_fx[k] = 9;
    end
    for (int c = 0; c < 60 && (n_rr < 4 || n_fx < 4); c++) begin
      tick();
      if (ready3r != 3'b000 && n_rr < 4) begin
        g_rr[n_rr] = oh_idx(ready3r);
        n_rr++;
      end
      if (ready3f != 3'b000 && n_fx < 4) begin
        g_fx[n_fx] = oh_idx(ready3f);
        n_fx++;
      end
    end
    chk("rr_grant0", 64'(g_rr[0]), 64'd0);
    chk("rr_grant1", 64'(g_rr[1]), 64'd1);
    chk("rr_grant2", 64'(g_rr[2]), 64'd2);
    chk("rr_grant3", 64'(g_rr[3]), 64'd0);
    for (int k = 0; k < 4; k++) chk("fx_grant", 64'(g_fx[k]), 64'd0);
    req_rd3 = 3'b000;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
